// File: rtl/text_render.sv
// Character-cell text renderer: walks a text RAM and a font ROM to turn a text page into per-pixel colour indices.
// Optional macro TEXT_CURSOR_EN adds a frame-rate blinking cursor that swaps a cell's fg/bg colours.
`timescale 1ns/1ps

module text_render #(
  parameter int WORD       = 32,
  parameter int ADDRW      = 12,
  parameter int COLS       = 80,
  parameter int ROWS       = 30,
  parameter int GLYPH_W    = 8,
  parameter int GLYPH_H    = 16,
  parameter int CIDXW      = 4,
  parameter int FONT_ADDRW = 12
) (
  input  logic                  clk_pix,
  input  logic                  rst_pix_n,
  input  logic                  frame,
  input  logic                  line,
  input  logic                  de,
  output logic [ADDRW-1:0]      addr_disp,
  input  logic [WORD-1:0]       dout_disp,
  output logic [FONT_ADDRW-1:0] font_addr,
  input  logic [GLYPH_W-1:0]    font_data,
  input  logic [6:0]            cursor_col,
  input  logic [4:0]            cursor_row,
  input  logic                  cursor_en,
  output logic                  pix_de,
  output logic [CIDXW-1:0]      pix_cidx
);

  localparam int GXW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int GYW = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam logic [GXW-1:0]   GX_LAST  = GXW'(GLYPH_W - 1);
  localparam logic [GYW-1:0]   GY_LAST  = GYW'(GLYPH_H - 1);
  localparam logic [4:0]       ROW_LAST = 5'(ROWS - 1);
  localparam logic [ADDRW-1:0] COLS_A   = ADDRW'(COLS);

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Reset asserts asynchronously but is released through a two-flop synchroniser.
  logic r_rst_meta;
  logic r_rst_sync;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  state_t r_state;
  state_t w_state_next;
  logic   w_frame;
  logic   w_active;
  logic   w_de0;

  assign w_frame  = frame & r_rst_sync;
  assign w_active = (r_state == ST_RUN);

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_state <= ST_WAIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Nothing reaches the pixel pipeline until the first frame pulse after reset.
  always_comb begin
    w_state_next = r_state;
    w_de0        = 1'b0;
    case (r_state)
      ST_WAIT: begin
        if (w_frame) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_de0 = de;
      end
      default: begin
        w_state_next = ST_WAIT;
      end
    endcase
  end

  logic [ADDRW-1:0] r_row_base;
  logic [ADDRW-1:0] r_addr;
  logic [GYW-1:0]   r_gy;
  logic [GXW-1:0]   r_gx;
  logic [6:0]       r_col;
  logic [4:0]       r_row;
  logic             r_first;

  logic [ADDRW-1:0] w_row_base_next;
  logic [ADDRW-1:0] w_addr_next;
  logic [GYW-1:0]   w_gy_next;
  logic [GXW-1:0]   w_gx_next;
  logic [6:0]       w_col_next;
  logic [4:0]       w_row_next;
  logic             w_first_next;
  logic [ADDRW-1:0] w_base_adv;

  assign w_base_adv = (r_row == ROW_LAST) ? '0 : r_row_base + COLS_A;

  // frame outranks line, and both outrank de counting in the same cycle.
  always_comb begin
    w_row_base_next = r_row_base;
    w_addr_next     = r_addr;
    w_gy_next       = r_gy;
    w_gx_next       = r_gx;
    w_col_next      = r_col;
    w_row_next      = r_row;
    w_first_next    = r_first;
    if (w_frame) begin
      w_row_base_next = '0;
      w_addr_next     = '0;
      w_gy_next       = '0;
      w_gx_next       = '0;
      w_col_next      = '0;
      w_row_next      = '0;
      w_first_next    = ~line;
    end else if (w_active && line) begin
      w_gx_next    = '0;
      w_col_next   = '0;
      w_first_next = 1'b0;
      w_addr_next  = r_row_base;
      if (!r_first) begin
        if (r_gy == GY_LAST) begin
          w_gy_next       = '0;
          w_row_base_next = w_base_adv;
          w_addr_next     = w_base_adv;
          w_row_next      = (r_row == ROW_LAST) ? 5'd0 : r_row + 5'd1;
        end else begin
          w_gy_next = r_gy + GYW'(1);
        end
      end
    end else if (w_active && de) begin
      if (r_gx == GX_LAST) begin
        w_gx_next   = '0;
        w_addr_next = r_addr + ADDRW'(1);
        w_col_next  = r_col + 7'd1;
      end else begin
        w_gx_next = r_gx + GXW'(1);
      end
    end
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_row_base <= '0;
      r_addr     <= '0;
      r_gy       <= '0;
      r_gx       <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_first    <= 1'b0;
    end else begin
      r_row_base <= w_row_base_next;
      r_addr     <= w_addr_next;
      r_gy       <= w_gy_next;
      r_gx       <= w_gx_next;
      r_col      <= w_col_next;
      r_row      <= w_row_next;
      r_first    <= w_first_next;
    end
  end

  assign addr_disp = r_addr;

  logic w_cur_hit;

`ifdef TEXT_CURSOR_EN
  logic [5:0] r_blink;

  // The first frame after reset only arms the renderer, so frame n sees blink == n.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_blink <= '0;
    end else if (w_frame && w_active) begin
      r_blink <= r_blink + 6'd1;
    end
  end

  assign w_cur_hit = cursor_en & r_blink[5] & (r_col == cursor_col) & (r_row == cursor_row);
`else
  logic w_unused_cursor;
  assign w_unused_cursor = ^{cursor_col, cursor_row, cursor_en};
  assign w_cur_hit       = 1'b0;
`endif

  logic w_unused_dout;
  assign w_unused_dout = ^dout_disp;

  // Stage 1: the text word arrives this cycle, so the font lookup address is formed combinationally.
  logic           r_de1;
  logic [GXW-1:0] r_gx1;
  logic [GYW-1:0] r_gy1;
  logic           r_cur1;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_de1  <= 1'b0;
      r_gx1  <= '0;
      r_gy1  <= '0;
      r_cur1 <= 1'b0;
    end else begin
      r_de1  <= w_de0;
      r_gx1  <= r_gx;
      r_gy1  <= r_gy;
      r_cur1 <= w_cur_hit;
    end
  end

  logic [CIDXW-1:0] w_fg;
  logic [CIDXW-1:0] w_bg;
  logic [8+GYW-1:0] w_font_full;

  assign w_fg        = dout_disp[WORD-1 -: CIDXW];
  assign w_bg        = dout_disp[WORD-1-CIDXW -: CIDXW];
  assign w_font_full = {dout_disp[7:0], r_gy1};
  assign font_addr   = r_de1 ? FONT_ADDRW'(w_font_full) : '0;

  // Stage 2: font row arrives this cycle; colours are swapped here for the cursor cell.
  logic             r_de2;
  logic [GXW-1:0]   r_gx2;
  logic [CIDXW-1:0] r_fg2;
  logic [CIDXW-1:0] r_bg2;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_de2 <= 1'b0;
      r_gx2 <= '0;
      r_fg2 <= '0;
      r_bg2 <= '0;
    end else begin
      r_de2 <= r_de1;
      r_gx2 <= r_gx1;
      r_fg2 <= r_cur1 ? w_bg : w_fg;
      r_bg2 <= r_cur1 ? w_fg : w_bg;
    end
  end

  logic [GXW-1:0] w_bit_sel;
  logic           r_pix_de;
  logic [CIDXW-1:0] r_pix_cidx;

  assign w_bit_sel = GX_LAST - r_gx2;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_pix_de   <= 1'b0;
      r_pix_cidx <= '0;
    end else begin
      r_pix_de   <= r_de2;
      r_pix_cidx <= r_de2 ? (font_data[w_bit_sel] ? r_fg2 : r_bg2) : '0;
    end
  end

  assign pix_de   = r_pix_de;
  assign pix_cidx = r_pix_cidx;

endmodule

// File: tb/tb_text_render.sv
// Scoreboard bench for text_render: a behavioural model predicts font addresses and pixel colours per de cycle.
`timescale 1ns/1ps

module tb_text_render;

  localparam int WORD  = 32;
  localparam int ADDRW = 12;
  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int GW    = 8;
  localparam int GH    = 16;
  localparam int CIDXW = 4;
  localparam int FAW   = 12;

  logic              clk_pix   = 1'b0;
  logic              rst_pix_n = 1'b0;
  logic              frame     = 1'b0;
  logic              line      = 1'b0;
  logic              de        = 1'b0;
  logic [ADDRW-1:0]  addr_disp;
  logic [WORD-1:0]   dout_disp = '0;
  logic [FAW-1:0]    font_addr;
  logic [GW-1:0]     font_data = '0;
  logic [6:0]        cursor_col = '0;
  logic [4:0]        cursor_row = '0;
  logic              cursor_en  = 1'b0;
  logic              pix_de;
  logic [CIDXW-1:0]  pix_cidx;

  text_render #(
    .WORD(WORD), .ADDRW(ADDRW), .COLS(COLS), .ROWS(ROWS),
    .GLYPH_W(GW), .GLYPH_H(GH), .CIDXW(CIDXW), .FONT_ADDRW(FAW)
  ) dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .frame(frame), .line(line), .de(de),
    .addr_disp(addr_disp), .dout_disp(dout_disp), .font_addr(font_addr), .font_data(font_data),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_en(cursor_en),
    .pix_de(pix_de), .pix_cidx(pix_cidx)
  );

  always #5 clk_pix = ~clk_pix;

  logic [WORD-1:0] mem  [0:(1<<ADDRW)-1];
  logic [GW-1:0]   font [0:(1<<FAW)-1];

  always @(posedge clk_pix) begin
    dout_disp <= mem[addr_disp];
    font_data <= font[font_addr];
  end

  int cyc = 0;
  always @(posedge clk_pix) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } exp_t;

  exp_t q_pix[$];
  exp_t q_fa[$];
  exp_t e_mon;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  int frame_idx = -1;
  int line_no   = -1;
  int pix_no    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int line_base(input int l);
    return ((l / GH) % ROWS) * COLS;
  endfunction

  function automatic void model_pix(input int l, input int p, output logic [31:0] fa, output logic [31:0] cidx);
    int               row, col, gx, a;
    logic [3:0]       gyv;
    logic [WORD-1:0]  w;
    logic [CIDXW-1:0] fg, bg, tmp;
    logic [FAW-1:0]   fad;
    logic [GW-1:0]    fr;
    gyv = 4'(l % GH);
    row = (l / GH) % ROWS;
    col = p / GW;
    gx  = p % GW;
    a   = (row * COLS + col) % (1 << ADDRW);
    w   = mem[a];
    fg  = w[31:28];
    bg  = w[27:24];
    fad = {w[7:0], gyv};
    fr  = font[fad];
`ifdef TEXT_CURSOR_EN
    if (cursor_en && ((frame_idx % 64) >= 32) && (col == int'(cursor_col)) && (row == int'(cursor_row))) begin
      tmp = fg;
      fg  = bg;
      bg  = tmp;
    end
`else
    tmp = '0;
`endif
    fa   = 32'(fad);
    cidx = 32'(fr[GW-1-gx] ? fg : bg);
  endfunction

  // One clock of stimulus; entered and left at 1 ns after a rising edge.
  task automatic step(input bit f, input bit ln, input bit d);
    logic [31:0] fa, cx;
    frame = f;
    line  = ln;
    de    = d;
    if (f) begin
      frame_idx++;
      line_no = ln ? 0 : -1;
      pix_no  = 0;
    end else if (ln && frame_idx >= 0) begin
      line_no++;
      pix_no = 0;
    end
    if (d && frame_idx >= 0 && line_no >= 0) begin
      model_pix(line_no, pix_no, fa, cx);
      q_fa.push_back('{cyc + 1, fa});
      q_pix.push_back('{cyc + 3, cx});
      pix_no++;
    end
    @(posedge clk_pix);
    #1;
    frame = 1'b0;
    line  = 1'b0;
    de    = 1'b0;
  endtask

  task automatic do_line(input int npix, input int gap);
    step(1'b0, 1'b1, 1'b0);
    check("addr_line", 32'(addr_disp), 32'(line_base(line_no)));
    $display("[TB] frame %0d line %0d addr_disp=%0d pixels=%0d", frame_idx, line_no, addr_disp, npix);
    step(1'b0, 1'b0, 1'b0);
    for (int p = 0; p < npix; p++) step(1'b0, 1'b0, 1'b1);
    for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk_pix) begin
    if (mon_en) begin
      if (q_fa.size() > 0 && q_fa[0].cyc == cyc) begin
        check("font_addr", 32'(font_addr), q_fa[0].val);
        void'(q_fa.pop_front());
      end
      if (pix_de) begin
        if (q_pix.size() == 0) begin
          check("pix_unexpected", 32'(pix_de), 32'd0);
        end else begin
          e_mon = q_pix.pop_front();
          check("pix_latency", 32'(cyc), 32'(e_mon.cyc));
          check("pix_cidx", 32'(pix_cidx), e_mon.val);
        end
      end else begin
        check("cidx_idle", 32'(pix_cidx), 32'd0);
        if (q_pix.size() > 0 && q_pix[0].cyc <= cyc) begin
          check("pix_missing", 32'(pix_de), 32'd1);
          void'(q_pix.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < (1 << ADDRW); i++) mem[i] = $urandom;
    for (int i = 0; i < (1 << FAW); i++) font[i] = 8'($urandom);
    mem[0]         = 32'h1200_0041;
    font[12'h410]  = 8'h18;

    // Reset state
    #2;
    check("rst_addr_disp", 32'(addr_disp), 32'd0);
    check("rst_font_addr", 32'(font_addr), 32'd0);
    check("rst_pix_de", 32'(pix_de), 32'd0);
    check("rst_pix_cidx", 32'(pix_cidx), 32'd0);
    repeat (3) @(posedge clk_pix);
    #1;
    rst_pix_n = 1'b1;
    repeat (4) step(1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;

    // Ignored before the first frame
    step(1'b0, 1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b0);

    // Full first line, then enough short lines to wrap the text rows
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    do_line(COLS * GW, 6);
    for (int l = 1; l <= ROWS * GH; l++) do_line(16, 3);

    // frame + line together while pixels are still in flight
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    check("addr_frame_line", 32'(addr_disp), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    repeat (16) step(1'b0, 1'b0, 1'b1);
    repeat (6) step(1'b0, 1'b0, 1'b0);
    do_line(16, 3);

    // Cursor blink across 64 frames, alternating between two cursor cells
    cursor_en  = 1'b1;
    cursor_row = 5'd0;
    for (int f = 0; f < 64; f++) begin
      cursor_col = 7'(f % 2);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      do_line(16, 4);
    end

    // Asynchronous reset in the middle of a line
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b1);
    de = 1'b1;
    #2;
    mon_en    = 1'b0;
    rst_pix_n = 1'b0;
    #1;
    check("arst_pix_de", 32'(pix_de), 32'd0);
    check("arst_pix_cidx", 32'(pix_cidx), 32'd0);
    check("arst_addr_disp", 32'(addr_disp), 32'd0);
    check("arst_font_addr", 32'(font_addr), 32'd0);
    de = 1'b0;
    q_pix.delete();
    q_fa.delete();
    frame_idx = -1;
    line_no   = -1;
    repeat (3) @(posedge clk_pix);
    #1;
    rst_pix_n = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    repeat (8) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    do_line(24, 4);
    do_line(24, 4);

    repeat (10) step(1'b0, 1'b0, 1'b0);
    check("q_pix_drained", 32'(q_pix.size()), 32'd0);
    check("q_fa_drained", 32'(q_fa.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/text_render.md
TEXT_RENDER -- requirements
Module: text_render

Interface
REQ-001 Parameter WORD, default 32, text word width (bits).
REQ-002 Parameter ADDRW, default 12, text RAM address width.
REQ-003 Parameter COLS, default 80, text columns; ROWS, default 30, text rows.
REQ-004 Parameter GLYPH_W, default 8, glyph width (px); GLYPH_H, default 16, glyph height (px, power of two).
REQ-005 Parameter CIDXW, default 4, colour index width; FONT_ADDRW, default 12, font ROM address width.
REQ-006 One clock; reset is asynchronous and active-low: clk_pix input 1, pixel clock; rst_pix_n input 1, async active-low reset.
REQ-007 frame  input  1  pulse, one cycle before first line pulse of a frame.
REQ-008 line  input  1  pulse, at least one cycle before first de cycle of each active line.
REQ-009 de  input  1  display enable, high for COLS*GLYPH_W cycles per active line.
REQ-010 addr_disp  output  ADDRW  text RAM display-port address (registered).
REQ-011 dout_disp  input  WORD  text RAM data, valid one cycle after addr_disp.
REQ-012 font_addr  output  FONT_ADDRW  font ROM address {glyph code, glyph line}.
REQ-013 font_data  input  GLYPH_W  font ROM row, valid one cycle after font_addr; MSB = leftmost pixel.
REQ-014 cursor_col  input  7 / cursor_row  input  5 / cursor_en  input  1  cursor cell and enable.
REQ-015 pix_de  output  1  pixel valid; pix_cidx  output  CIDXW  pixel colour index.

Function
REQ-016 Text word format: [WORD-1 -: CIDXW] foreground, next CIDXW bits background, [7:0] glyph code; remaining bits ignored.
REQ-017 frame SHALL set row_base=0, glyph line gy=0, row index=0, and mark the next line as first.
REQ-018 line SHALL set glyph x gx=0, column index=0, addr_disp=row_base; if not first line, first advance gy (gy==GLYPH_H-1: gy=0, row_base+=COLS, row index+1; else gy+1).
REQ-019 After ROWS text rows row_base and row index SHALL wrap to 0.
REQ-020 frame and line in the same cycle: frame SHALL take priority; that line is first line (addr_disp=0, gy=0).
REQ-021 Each de cycle gx SHALL increment; at gx==GLYPH_W-1, gx=0, addr_disp+1, column index+1; addr_disp wraps modulo 2^ADDRW.
REQ-022 Stage 1 (t+1): font_addr={dout_disp[7:0], gy}, colours, gx and de registered.
REQ-023 Stage 2 (t+2): pix_cidx = font_data bit (GLYPH_W-1-gx) ? fg : bg; pix_de = de delayed.
REQ-024 Latency de -> pix_de SHALL be exactly 3 cycles; throughput one pixel per cycle, no stalls.
REQ-025 pix_cidx SHALL be 0 whenever pix_de is 0.
REQ-026 frame mid-line SHALL reset counters immediately; pixels already in the pipeline SHALL complete unchanged.

Reset
REQ-027 While rst_pix_n low: addr_disp=0, font_addr=0, pix_de=0, pix_cidx=0, all counters, blink counter and pipeline registers 0.
REQ-028 Reset release SHALL be synchronised internally; first valid output requires a frame pulse.

Configuration
REQ-029 Macro TEXT_CURSOR_EN defined: 6-bit blink counter increments on each frame; when cursor_en=1, blink bit 5=1 and cell (column, row)==(cursor_col, cursor_row), fg and bg SHALL be swapped for that cell.
REQ-030 TEXT_CURSOR_EN undefined: cursor ports ignored, no blink counter, no swap; pixel output otherwise identical.

Verification
REQ-031 frame, line, 640 de cycles, RAM word 0 = 0x1200_0041, font row for 'A' line 0 = 0x18 -> font_addr=0x410; pix_cidx for px 0..7 = 2,2,2,1,1,2,2,2 at t+3.
REQ-032 17 lines after frame -> addr_disp at line 17 start = 80, gy=1.
REQ-033 frame+line same cycle mid-frame -> addr_disp=0, gy=0, in-flight pixels unchanged.
REQ-034 Cursor at (0,0), cursor_en=1, TEXT_CURSOR_EN defined, frames 32..63 -> cell 0 colours swapped; frames 0..31 not swapped; undefined -> never swapped.
REQ-035 rst_pix_n low mid-line -> pix_de=0, pix_cidx=0, addr_disp=0 same cycle, asynchronously.
REQ-036 480 lines -> after row 29 row_base wraps to 0; de gap cycles -> pix_de=0, pix_cidx=0.
